// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the iterative 32x32 multiplier.
package mul_pkg;

  localparam int OPND_W   = 32;
  localparam int SLICE_W  = 8;
  localparam int N_SLICES = 4;
  localparam int N_STEPS  = 16;
  localparam int PROD_W   = 64;
  localparam int STEP_W   = $clog2(N_STEPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul32_iter_wallace8.sv
// Combinational 8x8 -> 16 unsigned slice multiplier. The eight partial-product
// rows are reduced with a carry-save (3:2) tree down to two rows, then summed
// by a single carry-propagate adder.
module wallace8
  import mul_pkg::*;
(
  input  logic [SLICE_W-1:0]   x,
  input  logic [SLICE_W-1:0]   y,
  output logic [2*SLICE_W-1:0] p
);

  localparam int ROW_W = 2 * SLICE_W;
  typedef logic [ROW_W-1:0] row_t;

  function automatic row_t csa_sum(input row_t r0, input row_t r1, input row_t r2);
    return r0 ^ r1 ^ r2;
  endfunction

  // Carries shift out of the top column; the true product fits in 16 bits,
  // so dropping them keeps the sum exact.
  function automatic row_t csa_cry(input row_t r0, input row_t r1, input row_t r2);
    return ((r0 & r1) | (r0 & r2) | (r1 & r2)) << 1;
  endfunction

  row_t pp [SLICE_W];

  for (genvar k = 0; k < SLICE_W; k++) begin : g_pp
    assign pp[k] = {{SLICE_W{1'b0}}, x & {SLICE_W{y[k]}}} << k;
  end

  // 8 rows -> 6
  row_t s0, c0, s1, c1;
  assign s0 = csa_sum(pp[0], pp[1], pp[2]);
  assign c0 = csa_cry(pp[0], pp[1], pp[2]);
  assign s1 = csa_sum(pp[3], pp[4], pp[5]);
  assign c1 = csa_cry(pp[3], pp[4], pp[5]);

  // 6 rows -> 4
  row_t s2, c2, s3, c3;
  assign s2 = csa_sum(s0, c0, s1);
  assign c2 = csa_cry(s0, c0, s1);
  assign s3 = csa_sum(c1, pp[6], pp[7]);
  assign c3 = csa_cry(c1, pp[6], pp[7]);

  // 4 rows -> 3
  row_t s4, c4;
  assign s4 = csa_sum(s2, c2, s3);
  assign c4 = csa_cry(s2, c2, s3);

  // 3 rows -> 2
  row_t s5, c5;
  assign s5 = csa_sum(s4, c4, c3);
  assign c5 = csa_cry(s4, c4, c3);

  assign p = s5 + c5;

endmodule

// File: rtl/mul32_iter.sv
// Iterative 32x32 unsigned multiplier: one 8x8 slice product per cycle,
// aligned and accumulated into a 64-bit register over 16 steps.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | issuing byte pairs and accumulating slice products, busy high
// DONE  | product valid, held until out_ready
module mul32_iter
  import mul_pkg::*;
#(
  parameter int unsigned PP_REG = 0
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic              busy
);

  state_t              state;
  logic [OPND_W-1:0]   a_q;
  logic [OPND_W-1:0]   b_q;
  logic [PROD_W-1:0]   acc;
  // Extra MSB marks "all 16 byte pairs issued" so the pipelined variant can
  // stop issuing while the last slice is still in flight.
  logic [STEP_W:0]     step;

  assign in_ready  = (state == IDLE);
  assign busy      = (state == CALC);
  assign out_valid = (state == DONE);
  assign product   = acc;

  // Issue side: byte select and alignment for the current step
  logic                 issue;
  logic                 issue_last;
  logic [1:0]           bi;
  logic [1:0]           bj;
  logic [2:0]           bsum;
  logic [SLICE_W-1:0]   sa;
  logic [SLICE_W-1:0]   sb;
  logic [2*SLICE_W-1:0] pp_raw;
  logic [5:0]           sh_raw;

  assign issue      = (state == CALC) && !step[STEP_W];
  assign issue_last = issue && (step[STEP_W-1:0] == STEP_W'(N_STEPS - 1));
  assign bi         = step[1:0];
  assign bj         = step[3:2];
  assign bsum       = {1'b0, bi} + {1'b0, bj};
  assign sh_raw     = {bsum, 3'b000};
  assign sa         = a_q[{bi, 3'b000} +: SLICE_W];
  assign sb         = b_q[{bj, 3'b000} +: SLICE_W];

  wallace8 u_wallace8 (
    .x (sa),
    .y (sb),
    .p (pp_raw)
  );

  // Accumulate side: either straight from the slice multiplier or one stage late
  logic [2*SLICE_W-1:0] pp_acc;
  logic [5:0]           sh_acc;
  logic                 acc_en;
  logic                 acc_last;

  if (PP_REG != 0) begin : g_ppreg
    logic [2*SLICE_W-1:0] pp_q;
    logic [5:0]           sh_q;
    logic                 vld_q;
    logic                 last_q;

    // Slice product pipeline register with its shift amount and step tags
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pp_q   <= '0;
        sh_q   <= '0;
        vld_q  <= 1'b0;
        last_q <= 1'b0;
      end else begin
        vld_q  <= issue;
        last_q <= issue_last;
        if (issue) begin
          pp_q <= pp_raw;
          sh_q <= sh_raw;
        end
      end
    end

    assign pp_acc   = pp_q;
    assign sh_acc   = sh_q;
    assign acc_en   = vld_q;
    assign acc_last = last_q;
  end else begin : g_ppcomb
    assign pp_acc   = pp_raw;
    assign sh_acc   = sh_raw;
    assign acc_en   = issue;
    assign acc_last = issue_last;
  end

  logic [PROD_W-1:0] addend;
  logic [PROD_W:0]   sum;

  assign addend = PROD_W'(pp_acc) << sh_acc;
  assign sum    = {1'b0, acc} + {1'b0, addend};

  // Partial sums never exceed the final product, so bit 64 must stay clear
  carry_zero_a : assert property (@(posedge clk) disable iff (!rst_n) acc_en |-> !sum[PROD_W]);

  // Control FSM, operand capture, step counter and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      step  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            acc   <= '0;
            step  <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          if (issue) step <= step + (STEP_W + 1)'(1);
          if (acc_en) acc <= sum[PROD_W-1:0];
          if (acc_en && acc_last) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul32_iter.sv
// Bench for mul32_iter: one instance per PP_REG setting, directed scenarios on
// the unregistered variant, then concurrent random traffic on both.
module tb_mul32_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv   [2];
  logic        ir   [2];
  logic        ov   [2];
  logic        ordy [2];
  logic        bsy  [2];
  logic [31:0] opa  [2];
  logic [31:0] opb  [2];
  logic [63:0] prod [2];

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] q0 [$];
  logic [63:0] q1 [$];

  always #5 clk = ~clk;

  mul32_iter #(.PP_REG(0)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv[0]),
    .in_ready  (ir[0]),
    .a         (opa[0]),
    .b         (opb[0]),
    .out_valid (ov[0]),
    .out_ready (ordy[0]),
    .product   (prod[0]),
    .busy      (bsy[0])
  );

  mul32_iter #(.PP_REG(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv[1]),
    .in_ready  (ir[1]),
    .a         (opa[1]),
    .b         (opb[1]),
    .out_valid (ov[1]),
    .out_ready (ordy[1]),
    .product   (prod[1]),
    .busy      (bsy[1])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic push_exp(input int k, input logic [63:0] v);
    if (k == 0) q0.push_back(v);
    else        q1.push_back(v);
  endtask

  task automatic pop_exp(input int k, output logic [63:0] v, output bit ok);
    ok = 1'b0;
    v  = '0;
    if (k == 0 && q0.size() > 0) begin v = q0.pop_front(); ok = 1'b1; end
    if (k == 1 && q1.size() > 0) begin v = q1.pop_front(); ok = 1'b1; end
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send(input int k, input logic [31:0] x, input logic [31:0] y,
                      input bit hold, input bit push, output int waited);
    iv[k]  = 1'b1;
    opa[k] = x;
    opb[k] = y;
    waited = 0;
    while (ir[k] !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (ir[k] !== 1'b1) begin
      chk($sformatf("accept_timeout%0d", k), 64'd0, 64'd1);
      iv[k] = 1'b0;
      return;
    end
    if (push) push_exp(k, 64'(x) * 64'(y));
    @(negedge clk);
    if (!hold) iv[k] = 1'b0;
  endtask

  // Called at the negedge after accept; waits for the result, stalls, then takes it.
  task automatic recv(input int k, input int stall);
    int          cnt;
    int          nb;
    int          leak;
    logic [63:0] e;
    bit          ok;
    cnt  = 0;
    nb   = 0;
    leak = 0;
    while (ov[k] !== 1'b1 && cnt < 100) begin
      if (bsy[k] === 1'b1) nb++;
      if (ir[k] !== 1'b0) leak++;
      @(negedge clk);
      cnt++;
    end
    chk($sformatf("latency%0d", k), 64'(cnt), 64'(16 + k));
    chk($sformatf("busy_cycles%0d", k), 64'(nb), 64'(16 + k));
    chk($sformatf("in_ready_calc%0d", k), 64'(leak), 64'd0);
    pop_exp(k, e, ok);
    chk($sformatf("sb_nonempty%0d", k), 64'(ok), 64'd1);
    chk($sformatf("product%0d", k), prod[k], e);
    chk($sformatf("in_ready_done%0d", k), 64'(ir[k]), 64'd0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk($sformatf("hold_valid%0d", k), 64'(ov[k]), 64'd1);
      chk($sformatf("hold_product%0d", k), prod[k], e);
      chk($sformatf("hold_in_ready%0d", k), 64'(ir[k]), 64'd0);
    end
    ordy[k] = 1'b1;
    @(negedge clk);
    ordy[k] = 1'b0;
    chk($sformatf("valid_drop%0d", k), 64'(ov[k]), 64'd0);
    chk($sformatf("ready_back%0d", k), 64'(ir[k]), 64'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_run(input int k, input int n);
    int          w;
    int          st;
    int          gap;
    logic [31:0] x;
    logic [31:0] y;
    for (int i = 0; i < n; i++) begin
      x   = pick();
      y   = pick();
      gap = int'($urandom_range(0, 2));
      st  = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
      send(k, x, y, 1'b0, 1'b1, w);
      recv(k, st);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iv[k]   = 1'b0;
      ordy[k] = 1'b0;
      opa[k]  = '0;
      opb[k]  = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_in_ready", 64'(ir[0]), 64'd1);
    chk("rst_out_valid", 64'(ov[0]), 64'd0);
    chk("rst_busy", 64'(bsy[0]), 64'd0);
    chk("rst_product", prod[0], 64'd0);
    chk("rst_in_ready1", 64'(ir[1]), 64'd1);
    chk("rst_product1", prod[1], 64'd0);

    // all-ones operands on both latency variants
    send(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, w);
    recv(0, 0);
    send(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, w);
    recv(1, 0);

    // back-to-back with in_valid held high
    send(0, 32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 1'b1, w);
    opa[0] = 32'h0001_0000;
    opb[0] = 32'h0001_0000;
    recv(0, 0);
    send(0, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1, w);
    chk("b2b_accept_wait", 64'(w), 64'd0);
    recv(0, 0);

    // zero multiplicand still takes the full step count
    send(0, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b1, w);
    recv(0, 0);

    // result backpressure with new operands offered during CALC and DONE
    send(0, 32'hCAFE_F00D, 32'h0001_2345, 1'b0, 1'b1, w);
    iv[0]  = 1'b1;
    opa[0] = 32'd7;
    opb[0] = 32'd9;
    recv(0, 5);
    send(0, 32'd7, 32'd9, 1'b0, 1'b1, w);
    chk("bp_accept_wait", 64'(w), 64'd0);
    recv(0, 0);

    // asynchronous reset in the middle of CALC
    send(0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, w);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(ov[0]), 64'd0);
    chk("midrst_product", prod[0], 64'd0);
    chk("midrst_busy", 64'(bsy[0]), 64'd0);
    chk("midrst_in_ready", 64'(ir[0]), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_out_valid", 64'(ov[0]), 64'd0);
    send(0, 32'd3, 32'd5, 1'b0, 1'b1, w);
    recv(0, 0);

    // random traffic with stalls on both variants concurrently
    fork
      rand_run(0, 1000);
      rand_run(1, 1000);
    join

    chk("sb_drained0", 64'(q0.size()), 64'd0);
    chk("sb_drained1", 64'(q1.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
